// File: rtl/demux2_1_buf.sv
// Buffered 1-to-2 demultiplexer: routes valid/ready words from one producer into
// per-channel FIFOs (A/B) with registered head outputs and per-channel delivery counters.

module demux2_1_buf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  input  logic             i_cnt_clr,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic [CNT_W-1:0] r_cnt;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_valid  = (r_count != {CW{1'b0}});
  assign o_data   = r_head;
  assign o_cnt    = r_cnt;
  assign w_push   = i_push & ~o_full;
  assign w_pop    = o_valid & i_ready;
  assign w_rd_nxt = r_rd_ptr + AW'(1);

  // Occupancy next state
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Head register tracks the oldest entry; it holds its value when the FIFO drains
  always_comb begin
    w_head_nxt = r_head;
    if (r_count == {CW{1'b0}}) begin
      if (w_push) begin
        w_head_nxt = i_data;
      end else begin
        w_head_nxt = r_head;
      end
    end else if (w_pop) begin
      if (r_count == CW'(1)) begin
        if (w_push) begin
          w_head_nxt = i_data;
        end else begin
          w_head_nxt = r_head;
        end
      end else begin
        w_head_nxt = r_mem[w_rd_nxt];
      end
    end else begin
      w_head_nxt = r_head;
    end
  end

  // Storage, pointers, occupancy, head and delivery counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_head   <= {WIDTH{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
      // Clear takes priority over a same-cycle delivery
      if (i_cnt_clr) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (w_pop) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
endmodule

module demux2_1_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);
  logic w_full_a;
  logic w_full_b;
  logic w_push_a;
  logic w_push_b;

  // Acceptance depends only on the selected channel's occupancy, never on its pop
  assign in_ready = rst_n & (in_sel ? ~w_full_b : ~w_full_a);
  assign w_push_a = in_valid & in_ready & ~in_sel;
  assign w_push_b = in_valid & in_ready & in_sel;

  demux2_1_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push_a),
    .i_data    (in_data),
    .i_ready   (a_ready),
    .i_cnt_clr (cnt_clr),
    .o_full    (w_full_a),
    .o_valid   (a_valid),
    .o_data    (a_data),
    .o_cnt     (cnt_a)
  );

  demux2_1_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push_b),
    .i_data    (in_data),
    .i_ready   (b_ready),
    .i_cnt_clr (cnt_clr),
    .o_full    (w_full_b),
    .o_valid   (b_valid),
    .o_data    (b_data),
    .o_cnt     (cnt_b)
  );
endmodule

// File: tb/tb_demux2_1_buf.sv
// Scoreboard bench for demux2_1_buf: per-channel expected-word queues and a
// reference delivery-counter model, checked on the falling clock edge.

module tb_demux2_1_buf;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  int               n_total;
  int               n_bad;
  logic [WIDTH-1:0] q_a [$];
  logic [WIDTH-1:0] q_b [$];
  logic [CNT_W-1:0] m_cnt_a;
  logic [CNT_W-1:0] m_cnt_b;

  demux2_1_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .cnt_clr  (cnt_clr),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: pops compared before pushes are recorded, counters vs model
  always @(negedge clk) begin
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      m_cnt_a <= '0;
      m_cnt_b <= '0;
    end else begin
      check_eq("cnt_a", cnt_a, m_cnt_a);
      check_eq("cnt_b", cnt_b, m_cnt_b);
      if (a_valid && a_ready) begin
        if (q_a.size() == 0) check_eq("a_spurious_pop", q_a.size(), 1);
        else check_eq("a_data", a_data, q_a.pop_front());
      end
      if (b_valid && b_ready) begin
        if (q_b.size() == 0) check_eq("b_spurious_pop", q_b.size(), 1);
        else check_eq("b_data", b_data, q_b.pop_front());
      end
      if (in_valid && in_ready) begin
        if (in_sel) q_b.push_back(in_data);
        else q_a.push_back(in_data);
        check_eq("occupancy_le_depth",
                 ((in_sel ? q_b.size() : q_a.size()) <= DEPTH) ? 1 : 0, 1);
      end
      if (cnt_clr) begin
        m_cnt_a <= '0;
        m_cnt_b <= '0;
      end else begin
        if (a_valid && a_ready) m_cnt_a <= m_cnt_a + 16'd1;
        if (b_valid && b_ready) m_cnt_b <= m_cnt_b + 16'd1;
      end
    end
  end

  // Offer one word and hold it until accepted; returns #1 after the accepting edge
  task automatic push_word(input logic sel, input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check_eq("push_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200; k++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      step(1);
    end
    check_eq("drain", q_a.size() + q_b.size(), 0);
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = '0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    cnt_clr  = 1'b0;

    // Reset state
    #12;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_a_valid", a_valid, 0);
    check_eq("rst_b_valid", b_valid, 0);
    check_eq("rst_a_data", a_data, 0);
    check_eq("rst_b_data", b_data, 0);
    check_eq("rst_cnt_a", cnt_a, 0);
    check_eq("rst_cnt_b", cnt_b, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check_eq("release_in_ready", in_ready, 1);
    step(1);

    // Routing and per-channel order
    a_ready = 1'b1;
    b_ready = 1'b1;
    push_word(1'b0, 32'h1111_1111);
    push_word(1'b1, 32'h2222_2222);
    push_word(1'b0, 32'h3333_3333);
    wait_drain();
    step(1);
    check_eq("route_cnt_a", cnt_a, 2);
    check_eq("route_cnt_b", cnt_b, 1);

    // Reset mid-traffic with both FIFOs holding two words
    a_ready = 1'b0;
    b_ready = 1'b0;
    push_word(1'b0, 32'hA000_0001);
    push_word(1'b0, 32'hA000_0002);
    push_word(1'b1, 32'hB000_0001);
    push_word(1'b1, 32'hB000_0002);
    check_eq("pre_rst_a_valid", a_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_a_valid", a_valid, 0);
    check_eq("midrst_b_valid", b_valid, 0);
    check_eq("midrst_cnt_a", cnt_a, 0);
    check_eq("midrst_cnt_b", cnt_b, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check_eq("midrst_release_ready", in_ready, 1);
    a_ready = 1'b1;
    b_ready = 1'b1;
    step(3);
    check_eq("flush_a_valid", a_valid, 0);
    check_eq("flush_b_valid", b_valid, 0);

    // Backpressure isolation between channels
    a_ready = 1'b0;
    push_word(1'b0, 32'hC000_0001);
    push_word(1'b0, 32'hC000_0002);
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 32'hC000_0003;
    @(negedge clk);
    check_eq("bp_a_full_ready", in_ready, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    push_word(1'b1, 32'hD000_0001);
    step(2);
    check_eq("bp_b_delivered", q_b.size(), 0);
    check_eq("bp_a_held", q_a.size(), 2);
    a_ready = 1'b1;
    push_word(1'b0, 32'hC000_0003);
    wait_drain();

    // Full channel: no bypass even with a concurrent pop
    a_ready = 1'b0;
    push_word(1'b0, 32'hE000_0001);
    push_word(1'b0, 32'hE000_0002);
    a_ready  = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 32'hE000_0003;
    @(negedge clk);
    check_eq("nobypass_ready", in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("after_pop_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_drain();

    // Sustained throughput across pointer wrap
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push_word(1'b0, 32'h5000_0000 + i);
      check_eq("tput_a_valid", a_valid, 1);
    end
    step(1);
    check_eq("tput_end_valid", a_valid, 0);
    check_eq("tput_cnt_a", cnt_a, 20);

    // Counter rollover
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      push_word(1'b0, i);
    end
    wait_drain();
    step(1);
    check_eq("roll_cnt_max", cnt_a, 16'hFFFF);
    push_word(1'b0, 32'h0BAD_F00D);
    wait_drain();
    step(1);
    check_eq("roll_cnt_wrap", cnt_a, 0);

    // Clear wins over a same-cycle pop
    b_ready = 1'b0;
    push_word(1'b1, 32'hF000_0001);
    check_eq("clr_b_valid", b_valid, 1);
    b_ready = 1'b1;
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    check_eq("clr_cnt_b", cnt_b, 0);
    check_eq("clr_b_drained", b_valid, 0);
    step(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
